// File: rtl/cu_pkg.sv
// Shared encodings for the basic-computer control unit: bus selects,
// opcodes, ALU operations and register-reference bit positions.
package cu_pkg;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam logic [2:0] ALU_AND     = 3'd0;
    localparam logic [2:0] ALU_ADD     = 3'd1;
    localparam logic [2:0] ALU_PASS_DR = 3'd2;
    localparam logic [2:0] ALU_CMA     = 3'd3;
    localparam logic [2:0] ALU_CIR     = 3'd4;
    localparam logic [2:0] ALU_CIL     = 3'd5;

    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

    // True when exactly one register-reference bit is set.
    function automatic logic one_hot12(input logic [11:0] v);
        return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
    endfunction

endpackage

// File: rtl/control_unit_sequence_counter.sv
// Timing-state counter: hold freezes it, clr returns it to T0, inc steps it.
module sequence_counter #(
    parameter int SC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    input  logic                hold,
    output logic [SC_WIDTH-1:0] count
);

    // Counter register; hold has priority so a halted machine stays at T0.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (hold)
            count <= count;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + SC_WIDTH'(1);
    end

endmodule

// File: rtl/control_unit.sv
// Timing and control for the basic computer: decodes SC, IR and flags into
// bus select, register strobes and ALU op for the common-bus datapath.
// Optional build macro CU_ILLEGAL_HALT_EN: malformed register-reference and
// all I/O instructions halt the machine and raise a sticky illegal flag.
//
// state | meaning
// T0    | AR <- PC
// T1    | IR <- M[AR], PC <- PC + 1
// T2    | AR <- IR[11:0]
// T3    | register-ref / I/O execute, or indirect AR <- M[AR]
// T4    | memory-ref first execute cycle
// T5    | memory-ref second execute cycle
// T6    | ISZ write-back and skip
// T7+   | undecoded, return to T0
module control_unit
    import cu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    ir,
    input  logic                dr_zero,
    input  logic                ac_msb,
    input  logic                ac_zero,
    input  logic                e_flag,
    output logic [2:0]          bus_sel,
    output logic                ar_ld,
    output logic                ar_inc,
    output logic                pc_ld,
    output logic                pc_inc,
    output logic                dr_ld,
    output logic                dr_inc,
    output logic                ac_ld,
    output logic                ac_clr,
    output logic                ac_inc,
    output logic                ir_ld,
    output logic                mem_wr,
    output logic [2:0]          alu_op,
    output logic                e_ld,
    output logic                e_clr,
    output logic                e_cmp,
`ifdef CU_ILLEGAL_HALT_EN
    output logic                illegal,
`endif
    output logic                halted,
    output logic [SC_WIDTH-1:0] sc
);

    logic [SC_WIDTH-1:0] sc_q;
    logic                sc_clr;
    logic                halted_q;
    logic                hlt_set;
    logic                rr_ok;
    logic                i_bit;
    logic [2:0]          op;
    logic [11:0]         rr;
`ifdef CU_ILLEGAL_HALT_EN
    logic                ill_set;
    logic                illegal_q;
`endif

    assign i_bit = ir[WIDTH-1];
    assign op    = ir[WIDTH-2 -: 3];
    assign rr    = ir[11:0];

    sequence_counter #(.SC_WIDTH(SC_WIDTH)) u_sc (
        .clk   (clk),
        .rst   (rst),
        .inc   (!sc_clr),
        .clr   (sc_clr),
        .hold  (halted_q),
        .count (sc_q)
    );

    // Halt and illegal flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
`ifdef CU_ILLEGAL_HALT_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            if (hlt_set)
                halted_q <= 1'b1;
`ifdef CU_ILLEGAL_HALT_EN
            if (ill_set) begin
                halted_q  <= 1'b1;
                illegal_q <= 1'b1;
            end
`endif
        end
    end

    // Next-state: decide where each instruction ends and SC returns to T0.
    always_comb begin
        sc_clr = 1'b0;
        case (sc_q)
            SC_WIDTH'(0), SC_WIDTH'(1), SC_WIDTH'(2): sc_clr = 1'b0;
            SC_WIDTH'(3): sc_clr = (op == OP_REG);
            SC_WIDTH'(4): sc_clr = (op == OP_STA) || (op == OP_BUN) || (op == OP_REG);
            SC_WIDTH'(5): sc_clr = (op != OP_ISZ);
            default:      sc_clr = 1'b1;
        endcase
    end

    // Output decode of the current timing state; silent in reset and halt.
    always_comb begin
        bus_sel = BUS_NONE;
        ar_ld   = 1'b0;
        ar_inc  = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        dr_ld   = 1'b0;
        dr_inc  = 1'b0;
        ac_ld   = 1'b0;
        ac_clr  = 1'b0;
        ac_inc  = 1'b0;
        ir_ld   = 1'b0;
        mem_wr  = 1'b0;
        alu_op  = ALU_AND;
        e_ld    = 1'b0;
        e_clr   = 1'b0;
        e_cmp   = 1'b0;
        hlt_set = 1'b0;
        rr_ok   = 1'b0;
`ifdef CU_ILLEGAL_HALT_EN
        ill_set = 1'b0;
`endif
        if (!rst && !halted_q) begin
            case (sc_q)
                SC_WIDTH'(0): begin
                    bus_sel = BUS_PC;
                    ar_ld   = 1'b1;
                end
                SC_WIDTH'(1): begin
                    bus_sel = BUS_MEM;
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                end
                SC_WIDTH'(2): begin
                    bus_sel = BUS_IR;
                    ar_ld   = 1'b1;
                end
                SC_WIDTH'(3): begin
                    if (op == OP_REG) begin
                        rr_ok = !i_bit;
`ifdef CU_ILLEGAL_HALT_EN
                        rr_ok   = !i_bit && one_hot12(rr);
                        ill_set = !rr_ok;
`endif
                        if (rr_ok) begin
                            ac_clr = rr[RR_CLA];
                            e_clr  = rr[RR_CLE];
                            ac_ld  = (rr[RR_CMA] | rr[RR_CIR] | rr[RR_CIL]) & ~rr[RR_CLA];
                            ac_inc = rr[RR_INC] & ~rr[RR_CLA];
                            e_cmp  = rr[RR_CME] & ~rr[RR_CLE];
                            e_ld   = (rr[RR_CIR] | rr[RR_CIL]) & ~rr[RR_CLE];
                            if (rr[RR_CMA])
                                alu_op = ALU_CMA;
                            else if (rr[RR_CIL])
                                alu_op = ALU_CIL;
                            else if (rr[RR_CIR])
                                alu_op = ALU_CIR;
                            pc_inc = (rr[RR_SPA] & ~ac_msb) | (rr[RR_SNA] & ac_msb) |
                                     (rr[RR_SZA] & ac_zero) | (rr[RR_SZE] & ~e_flag);
                            hlt_set = rr[RR_HLT];
                        end
                    end else if (i_bit) begin
                        bus_sel = BUS_MEM;
                        ar_ld   = 1'b1;
                    end
                end
                SC_WIDTH'(4): begin
                    case (op)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            bus_sel = BUS_MEM;
                            dr_ld   = 1'b1;
                        end
                        OP_STA: begin
                            bus_sel = BUS_AC;
                            mem_wr  = 1'b1;
                        end
                        OP_BUN: begin
                            bus_sel = BUS_AR;
                            pc_ld   = 1'b1;
                        end
                        OP_BSA: begin
                            bus_sel = BUS_PC;
                            mem_wr  = 1'b1;
                            ar_inc  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                SC_WIDTH'(5): begin
                    case (op)
                        OP_AND: begin
                            ac_ld  = 1'b1;
                            alu_op = ALU_AND;
                        end
                        OP_ADD: begin
                            ac_ld  = 1'b1;
                            alu_op = ALU_ADD;
                            e_ld   = 1'b1;
                        end
                        OP_LDA: begin
                            ac_ld  = 1'b1;
                            alu_op = ALU_PASS_DR;
                        end
                        OP_BSA: begin
                            bus_sel = BUS_AR;
                            pc_ld   = 1'b1;
                        end
                        OP_ISZ: dr_inc = 1'b1;
                        default: ;
                    endcase
                end
                SC_WIDTH'(6): begin
                    if (op == OP_ISZ) begin
                        bus_sel = BUS_DR;
                        mem_wr  = 1'b1;
                        pc_inc  = dr_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sc     = rst ? '0 : sc_q;
    assign halted = rst ? 1'b0 : halted_q;
`ifdef CU_ILLEGAL_HALT_EN
    assign illegal = rst ? 1'b0 : illegal_q;
`endif

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Timing and control stage directly upstream of the 8:1 common-bus multiplexer in the basic computer. A sequence counter (SC) steps T0..T15. SC state, the latched IR, and status flags drive the 3-bit bus select and all register load/increment/clear strobes. Implements fetch, decode, indirect addressing, the seven memory-reference instructions and the register-reference instructions.

Parameters:
WIDTH, 16, datapath word width; the IR field layout below requires 16
SC_WIDTH, 4, sequence counter width (T0..T15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
ir  input  WIDTH  IR contents: I=ir[15], opcode D=ir[14:12], reg-ref bits ir[11:0]
dr_zero  input  1  DR == 0
ac_msb  input  1  AC[15]
ac_zero  input  1  AC == 0
e_flag  input  1  E flip-flop value
bus_sel  output  3  to mux selects: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory
ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ac_clr, ac_inc, ir_ld  output  1 each  register strobes
mem_wr  output  1  memory write at AR
alu_op  output  3  0 AND, 1 ADD, 2 PASS_DR, 3 CMA, 4 CIR, 5 CIL
e_ld, e_clr, e_cmp  output  1 each  E from ALU carry/shift-out; clear; complement
halted  output  1  HLT executed
sc  output  SC_WIDTH  current timing state (debug)

Behaviour:
- Strobes are combinational decodes of current SC, IR and flags. The targeted register updates on the next clk edge.
- SC increments every cycle. "SC clear" means SC = 0 next cycle.
- rst: SC = 0, halted = 0; every output forced to 0 while rst is high. The cycle after rst deasserts is T0.
- halted = 1: SC frozen at 0, all strobes 0, bus_sel 0. Cleared only by rst.
- T0: bus_sel=2, ar_ld.
- T1: bus_sel=7, ir_ld, pc_inc.
- T2: bus_sel=5, ar_ld (AR <- IR[11:0]).
- T3:
  - D=7, I=0: register-reference, then SC clear.
  - D=7, I=1: I/O, executes as NOP, then SC clear.
  - D<7, I=1: bus_sel=7, ar_ld (indirect).
  - D<7, I=0: idle.
- Memory-reference, from T4:
  - AND/ADD/LDA (D=0/1/2):
    - T4: bus_sel=7, dr_ld.
    - T5: ac_ld, alu_op 0/1/2, SC clear. ADD also asserts e_ld.
  - STA (D=3): T4 bus_sel=4, mem_wr, SC clear.
  - BUN (D=4): T4 bus_sel=1, pc_ld, SC clear.
  - BSA (D=5):
    - T4: bus_sel=2, mem_wr, ar_inc.
    - T5: bus_sel=1, pc_ld, SC clear.
  - ISZ (D=6):
    - T4: bus_sel=7, dr_ld.
    - T5: dr_inc.
    - T6: bus_sel=3, mem_wr, pc_inc if dr_zero, SC clear.
- Register-reference bits, at T3:
  - 11 CLA: ac_clr.
  - 10 CLE: e_clr.
  - 9 CMA: ac_ld, alu_op 3.
  - 8 CME: e_cmp.
  - 7 CIR: ac_ld, alu_op 4, e_ld.
  - 6 CIL: ac_ld, alu_op 5, e_ld.
  - 5 INC: ac_inc.
  - 4 SPA: pc_inc if !ac_msb.
  - 3 SNA: pc_inc if ac_msb.
  - 2 SZA: pc_inc if ac_zero.
  - 1 SZE: pc_inc if !e_flag.
  - 0 HLT: halted <= 1.
- Multiple register-reference bits set:
  - All strobes OR together; pc_inc is a single increment.
  - alu_op priority: CMA > CIL > CIR.
  - ac_clr dominates ac_ld/ac_inc; e_clr dominates e_cmp/e_ld.
- bus_sel is 0 in any state not listed. SC never exceeds 6 in legal flow. If SC reaches an undecoded value, SC clear next cycle.

Optional Feature:
CU_ILLEGAL_HALT_EN
- Defined:
  - At T3, a register-reference with zero bits or more than one bit set, or any I/O instruction (D=7, I=1), suppresses all T3 strobes and sets halted.
  - Adds output illegal (1 bit, reset 0, sticky until rst).
- Undefined: the multi-bit OR and I/O-as-NOP behaviour above; no illegal port.

Decomposition:
- Package cu_pkg holds:
  - bus-select constants BUS_NONE..BUS_MEM (0..7);
  - opcode constants OP_AND..OP_ISZ, OP_REG (7);
  - ALU_* encodings;
  - reg-ref bit indices RR_CLA..RR_HLT.
- One sub-module, sequence_counter: SC_WIDTH-bit counter with inc, sync clr and hold (halt) inputs.

Test Plan:
- Reset then run with ir=16'h2123 (LDA direct):
  - T0 bus_sel=2/ar_ld; T1 bus_sel=7/ir_ld/pc_inc; T2 bus_sel=5/ar_ld; T3 idle;
  - T4 bus_sel=7/dr_ld; T5 ac_ld, alu_op=2; then sc=0.
- ir=16'h9050 (ADD indirect): T3 bus_sel=7/ar_ld; T5 alu_op=1, ac_ld, e_ld.
- ir=16'h6010 (ISZ):
  - dr_zero=1 at T6: pc_inc=1, mem_wr=1, bus_sel=3.
  - Repeat with dr_zero=0: pc_inc=0.
- ir=16'h7004 (SZA) with ac_zero=1: pc_inc=1 at T3, sc=0 next.
- ir=16'h7001 (HLT): halted=1 from the next cycle; sc stays 0 and all strobes stay 0 for 20 cycles; rst clears halted.
- rst asserted at T5 of ADD: all outputs 0 that cycle; sc=0 and T0 decode in the first cycle after release.
- With CU_ILLEGAL_HALT_EN: ir=16'h7C00 (two bits) -> no ac_clr/e_clr at T3, illegal=1, halted=1.
